mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 28 ++
 rtl/data_ram.sv | 26 ++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, EX/MEM register layout and address check for the MEM stage
package mem_pkg;

  localparam int DEPTH_DEFAULT = 512;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic        memWrite;
    logic        branch;
    logic        jump;
    logic [5:0]  aluOp;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic [31:0] pcBranch;
    logic [4:0]  wbAddr;
  } exmem_t;

  // Word-aligned and inside the RAM window; limit is the RAM size in bytes.
  function automatic logic addrLegal(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - word-wide data RAM, synchronous write port and combinational read port
module data_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  // Contents start at zero and survive pipeline reset.
  logic [31:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM pipeline register plus data memory access, fault tracking and store counting
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [5:0]  ALUopE,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] WriteData_in,
  input  logic [31:0] PCBranch_in,
  input  logic [4:0]  wb_addr_in,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        JumpM,
  output logic [5:0]  ALUopM,
  output logic [31:0] ALUOutM,
  output logic [4:0]  wb_addr_M,
  output logic [31:0] ReadDataM,
  output logic        PCSrcM,
  output logic [31:0] PCBranchM,
  output logic        mem_fault,
  output logic [31:0] fault_addr,
  output logic [15:0] store_count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  exmem_t        exIn;
  exmem_t        exNext;
  exmem_t        memReg;
  logic          firstCycle;
  logic          holdReg;
  logic          access;
  logic          legal;
  logic          storeFire;
  logic          faultEvent;
  logic [AW-1:0] wordIdx;
  logic [31:0]   ramRdata;

  assign exIn = '{RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE,
                  ALUopE, ALUOut_in, WriteData_in, PCBranch_in, wb_addr_in};

  // The first rise after reset release always captures, even under stall.
  assign holdReg = stall_in && !firstCycle;

  always_comb begin
    exNext = exIn;
    if (flush_in) begin
      exNext.regWrite = 1'b0;
      exNext.memtoReg = 1'b0;
      exNext.memWrite = 1'b0;
      exNext.branch   = 1'b0;
      exNext.jump     = 1'b0;
    end else if (holdReg) begin
      exNext = memReg;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      memReg     <= '0;
      firstCycle <= 1'b1;
    end else begin
      memReg     <= exNext;
      firstCycle <= 1'b0;
    end
  end

  assign access     = memReg.memWrite || memReg.memtoReg;
  assign legal      = addrLegal(memReg.aluOut, ADDR_LIMIT);
  assign wordIdx    = memReg.aluOut[AW+1:2];
  // A store held by stall commits only on the rise that releases it; flush does not cancel it.
  assign storeFire  = memReg.memWrite && legal && !stall_in;
  assign faultEvent = access && !legal;

  data_ram #(
    .DEPTH (DEPTH)
  ) u_data_ram (
    .CLK   (CLK),
    .we    (storeFire),
    .waddr (wordIdx),
    .wdata (memReg.writeData),
    .raddr (wordIdx),
    .rdata (ramRdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      store_count <= '0;
      mem_fault   <= 1'b0;
      fault_addr  <= '0;
    end else begin
      if (storeFire) begin
        store_count <= store_count + 16'd1;
      end
      if (faultEvent) begin
        mem_fault <= 1'b1;
        if (!mem_fault) begin
          fault_addr <= memReg.aluOut;
        end
      end
    end
  end

  assign RegWriteM = memReg.regWrite;
  assign MemtoRegM = memReg.memtoReg;
  assign JumpM     = memReg.jump;
  assign ALUopM    = memReg.aluOp;
  assign ALUOutM   = memReg.aluOut;
  assign wb_addr_M = memReg.wbAddr;
  assign PCBranchM = memReg.pcBranch;
  assign PCSrcM    = memReg.branch && (memReg.aluOut == 32'd0);
  assign ReadDataM = (memReg.memtoReg && legal) ? ramRdata : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven, scoreboard-checked bench for mem_stage
module tb_mem_stage;
  import mem_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        stall_in, flush_in;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
  logic [5:0]  ALUopE;
  logic [31:0] ALUOut_in, WriteData_in, PCBranch_in;
  logic [4:0]  wb_addr_in;
  logic        RegWriteM, MemtoRegM, JumpM;
  logic [5:0]  ALUopM;
  logic [31:0] ALUOutM;
  logic [4:0]  wb_addr_M;
  logic [31:0] ReadDataM;
  logic        PCSrcM;
  logic [31:0] PCBranchM;
  logic        mem_fault;
  logic [31:0] fault_addr;
  logic [15:0] store_count;

  mem_stage dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .MemWriteE    (MemWriteE),
    .BranchE      (BranchE),
    .JumpE        (JumpE),
    .ALUopE       (ALUopE),
    .ALUOut_in    (ALUOut_in),
    .WriteData_in (WriteData_in),
    .PCBranch_in  (PCBranch_in),
    .wb_addr_in   (wb_addr_in),
    .RegWriteM    (RegWriteM),
    .MemtoRegM    (MemtoRegM),
    .JumpM        (JumpM),
    .ALUopM       (ALUopM),
    .ALUOutM      (ALUOutM),
    .wb_addr_M    (wb_addr_M),
    .ReadDataM    (ReadDataM),
    .PCSrcM       (PCSrcM),
    .PCBranchM    (PCBranchM),
    .mem_fault    (mem_fault),
    .fault_addr   (fault_addr),
    .store_count  (store_count)
  );

  // ctl = {stall, flush, RegWrite, MemtoReg, MemWrite, Branch, Jump}
  typedef struct packed {
    logic [6:0]  ctl;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pcBr;
    logic [4:0]  wb;
  } in_t;

  // flg = {RegWriteM, MemtoRegM, JumpM, PCSrcM, mem_fault, checkDataFields}
  typedef struct packed {
    logic [5:0]  flg;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [4:0]  wb;
    logic [31:0] pcBr;
    logic [31:0] rd;
    logic [31:0] fAddr;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int NV = 12;
  localparam int STORES_BEFORE_WRAP = 4;

  vec_t vecs [NV];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    {stall_in, flush_in, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE} = v.ctl;
    ALUopE       = v.op;
    ALUOut_in    = v.addr;
    WriteData_in = v.wdata;
    PCBranch_in  = v.pcBr;
    wb_addr_in   = v.wb;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s.RegWriteM", tag), 32'(RegWriteM), 32'(e.flg[5]));
    chk($sformatf("%s.MemtoRegM", tag), 32'(MemtoRegM), 32'(e.flg[4]));
    chk($sformatf("%s.JumpM", tag), 32'(JumpM), 32'(e.flg[3]));
    chk($sformatf("%s.PCSrcM", tag), 32'(PCSrcM), 32'(e.flg[2]));
    chk($sformatf("%s.mem_fault", tag), 32'(mem_fault), 32'(e.flg[1]));
    chk($sformatf("%s.ReadDataM", tag), ReadDataM, e.rd);
    chk($sformatf("%s.fault_addr", tag), fault_addr, e.fAddr);
    chk($sformatf("%s.store_count", tag), 32'(store_count), 32'(e.cnt));
    if (e.flg[0]) begin
      chk($sformatf("%s.ALUopM", tag), 32'(ALUopM), 32'(e.op));
      chk($sformatf("%s.ALUOutM", tag), ALUOutM, e.addr);
      chk($sformatf("%s.wb_addr_M", tag), 32'(wb_addr_M), 32'(e.wb));
      chk($sformatf("%s.PCBranchM", tag), PCBranchM, e.pcBr);
    end
  endtask

  task automatic step(input in_t i, input exp_t e, input string tag);
    drive(i);
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    compare(tag);
  endtask

  task automatic checkZero(input string tag);
    chk($sformatf("%s.RegWriteM", tag), 32'(RegWriteM), 32'd0);
    chk($sformatf("%s.MemtoRegM", tag), 32'(MemtoRegM), 32'd0);
    chk($sformatf("%s.JumpM", tag), 32'(JumpM), 32'd0);
    chk($sformatf("%s.ALUopM", tag), 32'(ALUopM), 32'd0);
    chk($sformatf("%s.ALUOutM", tag), ALUOutM, 32'd0);
    chk($sformatf("%s.wb_addr_M", tag), 32'(wb_addr_M), 32'd0);
    chk($sformatf("%s.ReadDataM", tag), ReadDataM, 32'd0);
    chk($sformatf("%s.PCSrcM", tag), 32'(PCSrcM), 32'd0);
    chk($sformatf("%s.PCBranchM", tag), PCBranchM, 32'd0);
    chk($sformatf("%s.mem_fault", tag), 32'(mem_fault), 32'd0);
    chk($sformatf("%s.fault_addr", tag), fault_addr, 32'd0);
    chk($sformatf("%s.store_count", tag), 32'(store_count), 32'd0);
  endtask

  initial begin
    int nWrap;

    vecs[0]  = '{'{7'b0000100, OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0},
                 '{6'b000001, OP_SW, 32'h10, 5'd0, 32'h0, 32'h0, 32'h0, 16'd0}};
    vecs[1]  = '{'{7'b0011000, OP_LW, 32'h10, 32'h0, 32'h0, 5'd5},
                 '{6'b110001, OP_LW, 32'h10, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 16'd1}};
    vecs[2]  = '{'{7'b0000100, OP_SW, 32'h13, 32'h11111111, 32'h0, 5'd0},
                 '{6'b000001, OP_SW, 32'h13, 5'd0, 32'h0, 32'h0, 32'h0, 16'd1}};
    vecs[3]  = '{'{7'b0011000, OP_LW, 32'h13, 32'h0, 32'h0, 5'd6},
                 '{6'b110011, OP_LW, 32'h13, 5'd6, 32'h0, 32'h0, 32'h13, 16'd1}};
    vecs[4]  = '{'{7'b0000100, OP_SW, 32'h801, 32'h22222222, 32'h0, 5'd0},
                 '{6'b000011, OP_SW, 32'h801, 5'd0, 32'h0, 32'h0, 32'h13, 16'd1}};
    vecs[5]  = '{'{7'b0011000, OP_LW, 32'h10, 32'h0, 32'h0, 5'd7},
                 '{6'b110011, OP_LW, 32'h10, 5'd7, 32'h0, 32'hDEADBEEF, 32'h13, 16'd1}};
    vecs[6]  = '{'{7'b0000100, OP_SW, 32'h7FC, 32'hCAFEF00D, 32'h0, 5'd0},
                 '{6'b000011, OP_SW, 32'h7FC, 5'd0, 32'h0, 32'h0, 32'h13, 16'd1}};
    vecs[7]  = '{'{7'b0011000, OP_LW, 32'h7FC, 32'h0, 32'h0, 5'd8},
                 '{6'b110011, OP_LW, 32'h7FC, 5'd8, 32'h0, 32'hCAFEF00D, 32'h13, 16'd2}};
    vecs[8]  = '{'{7'b0000010, OP_BEQ, 32'h0, 32'h0, 32'h40, 5'd0},
                 '{6'b000111, OP_BEQ, 32'h0, 5'd0, 32'h40, 32'h0, 32'h13, 16'd2}};
    vecs[9]  = '{'{7'b0000010, OP_BEQ, 32'h5, 32'h0, 32'h80, 5'd0},
                 '{6'b000011, OP_BEQ, 32'h5, 5'd0, 32'h80, 32'h0, 32'h13, 16'd2}};
    vecs[10] = '{'{7'b1110001, 6'h00, 32'h99, 32'h0, 32'h0, 5'd3},
                 '{6'b000010, 6'h00, 32'h0, 5'd0, 32'h0, 32'h0, 32'h13, 16'd2}};
    vecs[11] = '{'{7'b0010001, 6'h02, 32'h1234, 32'h0, 32'h200, 5'd31},
                 '{6'b101011, 6'h02, 32'h1234, 5'd31, 32'h200, 32'h0, 32'h13, 16'd2}};

    RESET = 1'b1;
    drive('0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkZero("reset");
    RESET = 1'b0;

    for (int k = 0; k < NV; k++) begin
      step(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));
    end

    // Store held by three stall cycles must commit exactly once.
    step('{7'b0000100, OP_SW, 32'h20, 32'hA5A5A5A5, 32'h0, 5'd0},
         '{6'b000011, OP_SW, 32'h20, 5'd0, 32'h0, 32'h0, 32'h13, 16'd2}, "stall_sw");
    for (int s = 0; s < 3; s++) begin
      step('{7'b1011000, OP_LW, 32'h20, 32'h0, 32'h0, 5'd9},
           '{6'b000011, OP_SW, 32'h20, 5'd0, 32'h0, 32'h0, 32'h13, 16'd2}, $sformatf("stall_hold%0d", s));
    end
    step('{7'b0011000, OP_LW, 32'h20, 32'h0, 32'h0, 5'd9},
         '{6'b110011, OP_LW, 32'h20, 5'd9, 32'h0, 32'hA5A5A5A5, 32'h13, 16'd3}, "stall_release");
    step('0, '{6'b000011, 6'h00, 32'h0, 5'd0, 32'h0, 32'h0, 32'h13, 16'd3}, "stall_bubble");

    // Flush arriving while a store sits in MEM bubbles only the incoming instruction.
    step('{7'b0000100, OP_SW, 32'h24, 32'h5A5A5A5A, 32'h0, 5'd0},
         '{6'b000011, OP_SW, 32'h24, 5'd0, 32'h0, 32'h0, 32'h13, 16'd3}, "flush_sw");
    step('{7'b0111000, OP_LW, 32'h24, 32'h0, 32'h0, 5'd10},
         '{6'b000010, 6'h00, 32'h0, 5'd0, 32'h0, 32'h0, 32'h13, 16'd4}, "flush_bubble");
    step('{7'b0011000, OP_LW, 32'h24, 32'h0, 32'h0, 5'd10},
         '{6'b110011, OP_LW, 32'h24, 5'd10, 32'h0, 32'h5A5A5A5A, 32'h13, 16'd4}, "flush_lw");

    // Stream stores until the counter sits at 0xFFFF, then one more wraps it.
    nWrap = 16'hFFFF - STORES_BEFORE_WRAP;
    for (int n = 0; n < nWrap; n++) begin
      drive('{7'b0000100, OP_SW, 32'h100, 32'(n), 32'h0, 5'd0});
      @(posedge CLK);
      @(negedge CLK);
    end
    step('0, '{6'b000011, 6'h00, 32'h0, 5'd0, 32'h0, 32'h0, 32'h13, 16'hFFFF}, "count_max");
    step('{7'b0000100, OP_SW, 32'h104, 32'h77, 32'h0, 5'd0},
         '{6'b000011, OP_SW, 32'h104, 5'd0, 32'h0, 32'h0, 32'h13, 16'hFFFF}, "wrap_sw");
    step('0, '{6'b000011, 6'h00, 32'h0, 5'd0, 32'h0, 32'h0, 32'h13, 16'h0000}, "count_wrap");

    // Asynchronous reset with a store in MEM and stall asserted; RAM must be retained.
    step('{7'b0000100, OP_SW, 32'h108, 32'h88, 32'h0, 5'd0},
         '{6'b000011, OP_SW, 32'h108, 5'd0, 32'h0, 32'h0, 32'h13, 16'h0000}, "pre_reset_sw");
    drive('{7'b1011000, OP_LW, 32'h10, 32'h0, 32'h0, 5'd11});
    #2 RESET = 1'b1;
    #1 checkZero("async_reset");
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    step('{7'b1011000, OP_LW, 32'h10, 32'h0, 32'h0, 5'd11},
         '{6'b110001, OP_LW, 32'h10, 5'd11, 32'h0, 32'hDEADBEEF, 32'h0, 16'd0}, "release_capture");
    step('{7'b1011000, OP_LW, 32'h7FC, 32'h0, 32'h0, 5'd12},
         '{6'b110001, OP_LW, 32'h10, 5'd11, 32'h0, 32'hDEADBEEF, 32'h0, 16'd0}, "release_hold");
    step('{7'b0011000, OP_LW, 32'h7FC, 32'h0, 32'h0, 5'd12},
         '{6'b110001, OP_LW, 32'h7FC, 5'd12, 32'h0, 32'hCAFEF00D, 32'h0, 16'd0}, "retain_7fc");
    step('{7'b0011000, OP_LW, 32'h100, 32'h0, 32'h0, 5'd13},
         '{6'b110001, OP_LW, 32'h100, 5'd13, 32'h0, 32'h0000FFFA, 32'h0, 16'd0}, "retain_100");
    step('{7'b0011000, OP_LW, 32'h104, 32'h0, 32'h0, 5'd14},
         '{6'b110001, OP_LW, 32'h104, 5'd14, 32'h0, 32'h77, 32'h0, 16'd0}, "retain_104");
    step('{7'b0011000, OP_LW, 32'h108, 32'h0, 32'h0, 5'd15},
         '{6'b110001, OP_LW, 32'h108, 5'd15, 32'h0, 32'h0, 32'h0, 16'd0}, "reset_killed_sw");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
